// File: rtl/lfsr_checker.sv
// Downstream checker for the Galois LFSR pattern generator: predicts each next
// state word, locks after a run of correct words, then flywheels and counts errors.
module lfsr_checker #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  tap,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [SIZE-1:0]  in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);

  // LOCKED owns bit 1 alone so the locked output is a plain flop bit.
  localparam logic [1:0] HUNT   = 2'b00;
  localparam logic [1:0] VERIFY = 2'b01;
  localparam logic [1:0] LOCKED = 2'b10;

  logic [1:0]        state;
  logic [SIZE-1:0]   pred;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;

  logic [SIZE-1:0]   tap_eff;
  logic [SIZE-1:0]   step_data;
  logic [SIZE-1:0]   step_pred;
  logic [RUN_W-1:0]  run_inc;
  logic [MISS_W-1:0] miss_inc;
  logic              match;

  function automatic logic [SIZE-1:0] step(input logic [SIZE-1:0] s,
                                           input logic [SIZE-1:0] t);
    logic            fb;
    logic [SIZE-1:0] n;
    fb   = s[SIZE-1] ^ (s[SIZE-2:0] == '0);
    n    = '0;
    n[0] = fb;
    for (int unsigned b = 1; b < SIZE; b++) begin
      n[b] = t[b] ? (s[b-1] ^ fb) : s[b-1];
    end
    return n;
  endfunction

  // Degenerate masks fall back to a single tap at bit 1.
  assign tap_eff   = ((tap == '0) || (tap == '1)) ? SIZE'(2) : tap;
  assign step_data = step(in_data, tap_eff);
  assign step_pred = step(pred, tap_eff);
  assign match     = (in_data == pred);
  assign run_inc   = run + RUN_W'(1);
  assign miss_inc  = miss + MISS_W'(1);
  assign locked    = state[1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= HUNT;
      pred      <= '0;
      run       <= '0;
      miss      <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            pred  <= step_data;
            run   <= '0;
            state <= VERIFY;
          end
          VERIFY: begin
            pred <= step_data;
            if (match) begin
              run <= run_inc;
              if (run_inc == RUN_W'(LOCK_COUNT)) begin
                state <= LOCKED;
                miss  <= '0;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            pred <= step_pred;
            if (match) begin
              miss <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
              end
              miss <= miss_inc;
              if (miss_inc == MISS_W'(LOSS_COUNT)) begin
                state <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
